// File: rtl/div_module.sv
// ============================================================================
// Module   : div_module
// Purpose  : iterative signed restoring divider (32/16, one quotient bit per clock)
//            with a level-held ctrl / inputRDY / resultRDY / exception handshake.
//            Optional remainder output: define DIV_REMAINDER_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_module #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH_A-1:0] data_operandA,
  input  logic [WIDTH_B-1:0] data_operandB,
  input  logic               ctrl_DIV,
  output logic [WIDTH_A-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH_B-1:0] data_remainder,
`endif
  output logic               data_exception,
  output logic               data_inputRDY,
  output logic               data_resultRDY
);

  localparam int CNT_W = $clog2(WIDTH_A);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH_A-1:0] quot_q;
  logic [WIDTH_A-1:0] result_q;
  logic [WIDTH_B-1:0] div_q;
  logic [WIDTH_B-1:0] rem_q;
  logic               exc_q;
  logic               neg_q;
`ifdef DIV_REMAINDER_EN
  logic               rneg_q;
  logic [WIDTH_B-1:0] rem_res_q;
`endif

  logic               w_div_zero;
  logic               w_ovf;
  logic               w_last;
  logic [WIDTH_A-1:0] w_abs_a;
  logic [WIDTH_B-1:0] w_abs_b;
  logic [WIDTH_B:0]   w_shift;
  logic [WIDTH_B+1:0] w_trial;
  logic               w_trial_ok;
  logic [WIDTH_B:0]   w_rem_nxt;
  logic               w_unused;

  assign w_div_zero = (div_q == '0);
  assign w_ovf      = (quot_q == {1'b1, {(WIDTH_A-1){1'b0}}}) && (div_q == '1);
  assign w_last     = (cnt_q == CNT_W'(WIDTH_A-1));
  assign w_abs_a    = quot_q[WIDTH_A-1] ? -quot_q : quot_q;
  assign w_abs_b    = div_q[WIDTH_B-1]  ? -div_q  : div_q;

  // Partial remainder stays below |B|, so its top bit after restore is always zero.
  assign w_shift    = {rem_q, quot_q[WIDTH_A-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, div_q};
  assign w_trial_ok = ~w_trial[WIDTH_B+1];
  assign w_rem_nxt  = w_trial_ok ? w_trial[WIDTH_B:0] : w_shift;
  assign w_unused   = w_rem_nxt[WIDTH_B];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ctrl_DIV) state_d = S_PREP;
      S_PREP: begin
        if (!ctrl_DIV)                state_d = S_IDLE;
        else if (w_div_zero || w_ovf) state_d = S_DONE;
        else                          state_d = S_ITER;
      end
      S_ITER: begin
        if (!ctrl_DIV)   state_d = S_IDLE;
        else if (w_last) state_d = S_FIX;
      end
      S_FIX:  state_d = ctrl_DIV ? S_DONE : S_IDLE;
      S_DONE: if (!ctrl_DIV) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_inputRDY  = (state_q == S_IDLE);
    data_resultRDY = (state_q == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      quot_q    <= '0;
      result_q  <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      exc_q     <= 1'b0;
      neg_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rneg_q    <= 1'b0;
      rem_res_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_DIV) begin
            quot_q <= data_operandA;
            div_q  <= data_operandB;
            exc_q  <= 1'b0;
          end
        end
        S_PREP: begin
          if (ctrl_DIV) begin
            if (w_div_zero || w_ovf) begin
              result_q  <= w_div_zero ? '0 : quot_q;
              exc_q     <= 1'b1;
`ifdef DIV_REMAINDER_EN
              rem_res_q <= '0;
`endif
            end else begin
              quot_q <= w_abs_a;
              div_q  <= w_abs_b;
              neg_q  <= quot_q[WIDTH_A-1] ^ div_q[WIDTH_B-1];
`ifdef DIV_REMAINDER_EN
              rneg_q <= quot_q[WIDTH_A-1];
`endif
              rem_q  <= '0;
              cnt_q  <= '0;
            end
          end
        end
        S_ITER: begin
          if (ctrl_DIV) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            rem_q  <= w_rem_nxt[WIDTH_B-1:0];
            quot_q <= {quot_q[WIDTH_A-2:0], w_trial_ok};
          end
        end
        S_FIX: begin
          if (ctrl_DIV) begin
            result_q  <= neg_q ? -quot_q : quot_q;
`ifdef DIV_REMAINDER_EN
            rem_res_q <= rneg_q ? -rem_q : rem_q;
`endif
          end
        end
        S_DONE: begin
          if (!ctrl_DIV) exc_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_res_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_module.sv
// ============================================================================
// Module   : tb_div_module
// Purpose  : self-checking bench for div_module against an arithmetic reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_module;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [15:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  div_module #(.WIDTH_A(32), .WIDTH_B(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] q, output logic [15:0] r,
                       output logic exc, output int lat);
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 32'h0; r = 16'h0; exc = 1'b1; lat = 1;
    end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
      q = 32'h8000_0000; r = 16'h0; exc = 1'b1; lat = 1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0]; r = sr[15:0]; exc = 1'b0; lat = 34;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] eq;
    logic [15:0] er;
    logic        ee;
    int          elat;
    int          lat;
    model(a, b, eq, er, ee, elat);
    @(negedge clock);
    chk("idle_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    // Operands are scrambled after capture; the result must not depend on them.
    data_operandA = $urandom;
    data_operandB = 16'($urandom);
    chk("busy_inputRDY", {31'b0, data_inputRDY}, 32'd0);
    lat = 0;
    while (!data_resultRDY && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", data_result, eq);
    chk("exception", {31'b0, data_exception}, {31'b0, ee});
`ifdef DIV_REMAINDER_EN
    chk("remainder", {16'b0, data_remainder}, {16'b0, er});
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("hold_resultRDY", {31'b0, data_resultRDY}, 32'd1);
    chk("hold_result", data_result, eq);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    @(posedge clock); #1;
    chk("release_resultRDY", {31'b0, data_resultRDY}, 32'd0);
    chk("release_exception", {31'b0, data_exception}, 32'd0);
    chk("release_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    chk("release_result_kept", data_result, eq);
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    int          seen;

    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 16'h0;
    #2;
    chk("rst_result", data_result, 32'h0);
    chk("rst_exception", {31'b0, data_exception}, 32'd0);
    chk("rst_resultRDY", {31'b0, data_resultRDY}, 32'd0);
    chk("rst_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    do_op(32'd100, 16'd7);
    do_op(-32'sd100, 16'd7);
    do_op(32'd100, -16'sd7);
    do_op(-32'sd100, -16'sd7);
    do_op(32'd1234, 16'd0);
    do_op(32'h8000_0000, 16'hFFFF);
    do_op(32'h8000_0000, 16'h0001);
    do_op(32'h7FFF_FFFF, 16'h8000);
    do_op(32'h8000_0000, 16'h8000);
    do_op(32'd5, 16'd9);

    // Abort after ten iterations.
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 16'd3;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    seen = 0;
    repeat (11) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    @(posedge clock); #1;
    chk("abort_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen++;
    end
    chk("abort_no_resultRDY", seen, 0);
    do_op(32'd50, 16'd5);

    // Asynchronous reset in the middle of the iterations.
    @(negedge clock);
    data_operandA = 32'd99999;
    data_operandB = 16'd13;
    ctrl_DIV      = 1'b1;
    repeat (15) @(posedge clock);
    #3;
    reset_n  = 1'b0;
    ctrl_DIV = 1'b0;
    #1;
    chk("midrst_result", data_result, 32'h0);
    chk("midrst_exception", {31'b0, data_exception}, 32'd0);
    chk("midrst_resultRDY", {31'b0, data_resultRDY}, 32'd0);
    chk("midrst_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(32'd7, 16'd7);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      case (i % 4)
        0: rb = 16'($urandom_range(1, 15));
        1: ra = 32'($urandom_range(0, 5000));
        2: rb = -16'($urandom_range(1, 300));
        default: ;
      endcase
      do_op(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
